// File: rtl/uc_pkg.sv
// uc_pkg: shared state encoding, opcode constants and decode helpers for the
// multicycle control sequencer (unit_control_mc) and its latency counter.
package uc_pkg;

  // State encoding is visible on the debug/trace port, so values are fixed.
  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_WAIT_IN = 3'd5,
    ST_HALT    = 3'd6,
    ST_IRQ     = 3'd7
  } uc_state_e;

  // Opcode field (instruction bits [7:4]).
  localparam logic [3:0] OP_ALU   = 4'b0001;
  localparam logic [3:0] OP_MULT  = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_STORE = 4'b0101;
  localparam logic [3:0] OP_LOAD  = 4'b0110;
  localparam logic [3:0] OP_LI    = 4'b0111;
  localparam logic [3:0] OP_MOV   = 4'b1000;
  localparam logic [3:0] OP_IN    = 4'b1001;
  localparam logic [3:0] OP_OUT   = 4'b1010;

  // Operation field value that turns a STORE into a STOREINST.
  localparam logic [3:0] OPER_STOREINST = 4'b0001;

  // Full 8-bit instruction codes {opcode, operation}.
  localparam logic [7:0] CODE_NOOP       = 8'b0000_0000;
  localparam logic [7:0] CODE_HALT       = 8'b0000_0001;
  localparam logic [7:0] CODE_GETPC      = 8'b0000_0010;
  localparam logic [7:0] CODE_B          = 8'b0100_0000;
  localparam logic [7:0] CODE_BL         = 8'b0100_0001;
  localparam logic [7:0] CODE_GETTIME    = 8'b1011_0000;
  localparam logic [7:0] CODE_GETQUANTUM = 8'b1011_0011;

  // Datapath strobes that are decoded from the state being entered.
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic inst_write;
    logic in_req;
    logic new_out;
    logic pc_write;
  } uc_strobes_t;

  // True when the instruction writes a result into the register file.
  function automatic logic uc_writes_reg(input logic [3:0] opc, input logic [3:0] oper);
    logic [7:0] code;
    logic       wr;
    code = {opc, oper};
    case (opc)
      OP_ALU, OP_MULT, OP_DIV, OP_LOAD, OP_LI, OP_MOV, OP_IN: wr = 1'b1;
      default: wr = (code == CODE_BL) || (code == CODE_GETPC) ||
                    (code == CODE_GETTIME) || (code == CODE_GETQUANTUM);
    endcase
    return wr;
  endfunction

  // Successor of FETCH: short instructions skip DECODE, IN waits for the
  // device, HALT parks, everything else is decoded.
  function automatic uc_state_e uc_fetch_next(input logic [3:0] opc, input logic [3:0] oper);
    logic [7:0] code;
    uc_state_e  nxt;
    code = {opc, oper};
    if ((code == CODE_NOOP) || (code == CODE_B) || (code == CODE_BL) || (opc == OP_LI)) begin
      nxt = ST_COMMIT;
    end else if (opc == OP_IN) begin
      nxt = ST_WAIT_IN;
    end else if (code == CODE_HALT) begin
      nxt = ST_HALT;
    end else begin
      nxt = ST_DECODE;
    end
    return nxt;
  endfunction

  // Strobe pattern for a given state; only COMMIT, WAIT_IN and IRQ drive any.
  function automatic uc_strobes_t uc_strobes(input uc_state_e st, input logic [3:0] opc,
                                             input logic [3:0] oper);
    uc_strobes_t s;
    s = '0;
    case (st)
      ST_WAIT_IN: s.in_req = 1'b1;
      ST_COMMIT: begin
        s.pc_write  = 1'b1;
        s.reg_write = uc_writes_reg(opc, oper);
        if (opc == OP_STORE) begin
          if (oper == OPER_STOREINST) s.inst_write = 1'b1;
          else                        s.mem_write  = 1'b1;
        end
        s.new_out = (opc == OP_OUT);
      end
      ST_IRQ: begin
        // Vector load: PC takes the vector, datapath writes the link register.
        s.pc_write  = 1'b1;
        s.reg_write = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/uc_lat_counter.sv
// uc_lat_counter: EXEC-stretch counter. Loaded with LAT-1 on leaving DECODE,
// decremented once per EXEC cycle, zero flag tells the sequencer to commit.
module uc_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority over decrement; the two never coincide in practice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/unit_control_mc.sv
// unit_control_mc: multicycle control sequencer. Walks each instruction through
// FETCH/DECODE/EXEC/COMMIT, stretches EXEC for MULT/DIV/LOAD, handshakes IN,
// parks on HALT and strobes datapath write enables from registered outputs.
// Optional feature macro: UC_IRQ_EN (interrupt entry at instruction boundary).
module unit_control_mc #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 8,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic [3:0] operation,
  input  logic       in_ready,
  input  logic       wake_up,
  input  logic       irq,
  output logic [2:0] state,
  output logic       reg_write,
  output logic       mem_write,
  output logic       inst_write,
  output logic       in_req,
  output logic       new_out,
  output logic       pc_write,
  output logic       done_inst,
  output logic       irq_take
);

  import uc_pkg::*;

  // Counter preload values: EXEC spans exactly LAT cycles, so load LAT-1.
  localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] LOAD_LOAD = CNT_W'(LOAD_LAT - 1);

  uc_state_e        r_state;
  uc_state_e        w_state_next;
  uc_strobes_t      r_strobes;
  uc_strobes_t      w_strobes_next;
  logic             r_done_inst;
  logic             r_irq_take;
  logic             w_irq;
  logic             w_is_lat;
  logic [CNT_W-1:0] w_lat_load;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_zero;

`ifdef UC_IRQ_EN
  assign w_irq = irq;
`else
  // Interrupts compiled out: the port stays, the request is ignored.
  logic w_unused_irq;
  assign w_unused_irq = irq;
  assign w_irq        = 1'b0;
`endif

  // Classify the opcode into the multicycle classes and pick the preload.
  always_comb begin
    w_is_lat   = 1'b1;
    w_lat_load = '0;
    case (opcode)
      OP_MULT: w_lat_load = MUL_LOAD;
      OP_DIV:  w_lat_load = DIV_LOAD;
      OP_LOAD: w_lat_load = LOAD_LOAD;
      default: w_is_lat = 1'b0;
    endcase
  end

  assign w_cnt_load = (r_state == ST_DECODE) && w_is_lat;
  assign w_cnt_dec  = (r_state == ST_EXEC) && !w_cnt_zero;

  uc_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_cnt_load),
    .i_load_val(w_lat_load),
    .i_dec     (w_cnt_dec),
    .o_zero    (w_cnt_zero)
  );

  // Next-state logic; interrupts are only taken at instruction boundaries
  // (COMMIT) or from HALT, so no instruction is ever aborted.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT:    w_state_next = ST_FETCH;
      ST_FETCH:   w_state_next = uc_fetch_next(opcode, operation);
      ST_DECODE:  w_state_next = w_is_lat ? ST_EXEC : ST_COMMIT;
      ST_EXEC:    w_state_next = w_cnt_zero ? ST_COMMIT : ST_EXEC;
      ST_WAIT_IN: w_state_next = in_ready ? ST_COMMIT : ST_WAIT_IN;
      ST_HALT: begin
        // wake_up wins over a simultaneous irq: the HALT retires first.
        if (wake_up)    w_state_next = ST_COMMIT;
        else if (w_irq) w_state_next = ST_IRQ;
      end
      ST_COMMIT:  w_state_next = w_irq ? ST_IRQ : ST_FETCH;
      ST_IRQ:     w_state_next = ST_FETCH;
      default:    w_state_next = ST_INIT;
    endcase
  end

  // Strobes are a function of the state being entered so the registered
  // copies line up exactly with the state register.
  assign w_strobes_next = uc_strobes(w_state_next, opcode, operation);

  // Sequencer state plus registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_strobes   <= '0;
      r_done_inst <= 1'b0;
      r_irq_take  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_strobes   <= w_strobes_next;
      r_done_inst <= (r_state == ST_COMMIT);
`ifdef UC_IRQ_EN
      r_irq_take  <= (w_state_next == ST_IRQ);
`else
      r_irq_take  <= 1'b0;
`endif
    end
  end

  assign state      = r_state;
  assign reg_write  = r_strobes.reg_write;
  assign mem_write  = r_strobes.mem_write;
  assign inst_write = r_strobes.inst_write;
  assign in_req     = r_strobes.in_req;
  assign new_out    = r_strobes.new_out;
  assign pc_write   = r_strobes.pc_write;
  assign done_inst  = r_done_inst;
  assign irq_take   = r_irq_take;

endmodule
